// File: rtl/stream_scan_pkg.sv
// Shared types and constants for the stream pattern scanner: FSM states,
// power-up pattern configuration and the pattern-length clamp.
package stream_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0]  DEFAULT_PATTERN = 8'b0000_0110;
    localparam int unsigned DEFAULT_LEN     = 4;

    // A zero length behaves as a single-bit pattern; anything longer than the
    // history register is cut back to the history depth.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned pat_max);
        if (len == 0)
            return 1;
        if (len > pat_max)
            return pat_max;
        return len;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial Mealy detector: shifts one bit per valid cycle into a history
// register and flags when the newest len bits equal the programmed pattern.
module pattern_match_core
    import stream_scan_pkg::*;
#(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               clear,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic               match
);

    logic [PAT_MAX-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match;

    logic [PAT_MAX:0]   w_shift;
    logic [PAT_MAX-1:0] w_hist_next;
    logic [PAT_MAX-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_next;

    always_comb begin
        w_shift     = {r_hist, bit_in};
        w_hist_next = w_shift[PAT_MAX-1:0];
        w_fill_next = (r_fill >= LEN_W'(PAT_MAX)) ? r_fill : r_fill + LEN_W'(1);
        for (int i = 0; i < PAT_MAX; i++)
            w_mask[i] = (i < int'(len));
    end

    // Match is judged on the post-shift history so the completing bit counts.
    assign hit = bit_valid && (w_fill_next >= len) &&
                 ((w_hist_next & w_mask) == (pattern & w_mask));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= hit;
            if (clear) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (bit_valid) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
            end
        end
    end

    assign match = r_match;

endmodule

// File: rtl/stream_pattern_scanner.sv
// Word-stream front end for pattern_match_core: accepts a word, serialises it
// MSB first through the detector, and reports the saturating per-word match count.
module stream_pattern_scanner
    import stream_scan_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               cfg_busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count,
    output logic               match_pulse
);

    localparam int                 IDX_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [PAT_MAX-1:0] RST_PATTERN = PAT_MAX'(DEFAULT_PATTERN);
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(clamp_len(DEFAULT_LEN, PAT_MAX));

    state_t             r_state;
    state_t             w_state_next;
    logic [WORD_W-1:0]  r_word;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [PAT_MAX-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;

    logic w_accept;
    logic w_cfg_take;
    logic w_bit_valid;
    logic w_bit;
    logic w_hit;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bit_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_bit_valid = 1'b1;
                if (r_idx == '0)
                    w_state_next = REPORT;
            end
            REPORT: begin
                if (out_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Config changes only land while idle so an in-flight word sees one pattern.
    assign w_cfg_take = cfg_load && (r_state == IDLE);
    assign w_bit      = r_word[r_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_pat   <= RST_PATTERN;
            r_len   <= RST_LEN;
        end else begin
            r_state <= w_state_next;
            if (w_cfg_take) begin
                r_pat <= cfg_pattern;
                r_len <= LEN_W'(clamp_len(32'(cfg_len), PAT_MAX));
            end
            if (w_accept) begin
                r_idx <= IDX_W'(WORD_W - 1);
                r_cnt <= '0;
            end else begin
                if (w_bit_valid)
                    r_idx <= r_idx - IDX_W'(1);
                if (w_hit && (r_cnt != CNT_MAX))
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept)
            r_word <= in_data;
    end

    pattern_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .bit_valid (w_bit_valid),
        .bit_in    (w_bit),
        .clear     (w_cfg_take),
        .pattern   (r_pat),
        .len       (r_len),
        .hit       (w_hit),
        .match     (match_pulse)
    );

    assign in_ready  = (r_state == IDLE);
    assign cfg_busy  = (r_state != IDLE);
    assign out_valid = (r_state == REPORT);
    assign out_count = r_cnt;

endmodule
